// File: rtl/perm_pkg.sv
// Shared types and helpers for the bit-permutation arbiter.
package perm_pkg;

    typedef enum logic [1:0] {
        PERM_PASS = 2'd0,
        PERM_REV  = 2'd1,
        PERM_ROT  = 2'd2,
        PERM_RSVD = 2'd3
    } perm_mode_t;

    function automatic logic perm_is_legal(input perm_mode_t mode);
        return (mode != PERM_RSVD);
    endfunction

endpackage

// File: rtl/perm_net.sv
// Combinational W-bit permutation network: pass-through, bit-reverse or rotate-right-by-one.
module perm_net
    import perm_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] in,
    input  perm_mode_t   mode,
    output logic [W-1:0] out
);

    logic [W-1:0] rev;

    always_comb begin
        rev = '0;
        for (int i = 0; i < W; i++) begin
            rev[i] = in[W-1-i];
        end
    end

    // The reserved mode falls through to pass-through; flagging it is the caller's job.
    always_comb begin
        case (mode)
            PERM_REV: out = rev;
            PERM_ROT: out = {in[0], in[W-1:1]};
            default:  out = in;
        endcase
    end

endmodule

// File: rtl/perm_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one permutation network, feeding a single-entry output register.
module perm_rr_arbiter
    import perm_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][W-1:0]   req_data,
    input  logic [1:0][1:0]     req_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic                out_id,
    output logic                err
);

    logic         ptr_q, ptr_d;
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         id_q, id_d;
    logic         err_q, err_d;

    logic [1:0]   grant;
    logic         space;
    logic         xfer;
    logic         sel;
    perm_mode_t   sel_mode;
    logic [W-1:0] perm_out;

    always_comb begin
        grant = '0;
        if (req_valid == 2'b11) begin
            grant[ptr_q] = 1'b1;
        end else begin
            grant = req_valid;
        end
    end

    assign space     = !valid_q || out_ready;
    assign req_ready = rst ? 2'b00 : (grant & {2{space}});
    assign xfer      = |(req_valid & req_ready);
    assign sel       = grant[1];
    assign sel_mode  = perm_mode_t'(req_mode[sel]);

    perm_net #(.W(W)) u_perm_net (
        .in   (req_data[sel]),
        .mode (sel_mode),
        .out  (perm_out)
    );

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        if (xfer) begin
            data_d  = perm_out;
            id_d    = sel;
            valid_d = 1'b1;
            ptr_d   = ~sel;
            if (!perm_is_legal(sel_mode)) begin
                err_d = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign err       = err_q;

endmodule

// File: doc/perm_rr_arbiter.md
# perm_rr_arbiter

Round-robin arbiter and sequencer that shares one W-bit bit-permutation network between two requesters. Each requester presents a data word and a permutation mode: pass-through, bit-reverse or rotate-right-by-one. The block grants one requester per cycle, applies the selected permutation and registers the result into a single-entry output stage with valid/ready backpressure. It sits between vectorised bit-shuffle producers and a downstream consumer.

## Interface
Parameters:
- W, 4, data width in bits; must be ≥ 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  2  per-requester valid.
- req_ready  output  2  per-requester ready; at most one bit high in any cycle.
- req_data  input  2×W  per-requester data word.
- req_mode  input  2×2  per-requester mode: 0 PASS, 1 REV, 2 ROT, 3 reserved.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  permuted word.
- out_id  output  1  index of the requester that produced out_data.
- err  output  1  sticky flag; set when a word with mode 3 is accepted.

## Operation
- Permutation, for bit index i in 0..W-1:
  - PASS: out[i] = in[i].
  - REV: out[i] = in[W-1-i].
  - ROT: out[W-1] = in[0]; out[i] = in[i+1] for i < W-1.
  - Mode 3: result is computed as PASS, and err is set.
- Arbitration:
  - Combinational grant from req_valid and a 1-bit priority pointer ptr.
  - Only one requester valid: that requester is granted.
  - Both valid: requester ptr is granted.
  - Neither valid: no grant.
- Space and ready:
  - space = !out_valid || out_ready.
  - req_ready[k] = grant[k] && space.
  - A transfer happens on requester k when req_valid[k] && req_ready[k].
- On a transfer:
  - out_data <= perm(req_data[k], req_mode[k]); out_id <= k; out_valid <= 1.
  - ptr <= ~k, so the requester just served gets lowest priority next cycle.
- No transfer and out_ready && out_valid: out_valid <= 0. out_data and out_id hold their values.
- ptr changes only on a transfer.
- err is sticky and is cleared only by rst.
- Requesters may change req_data and req_mode freely while they are not being accepted. The block has no ordering assumption on them.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_id = 0, err = 0, ptr = 0. req_ready is 0 in the cycle rst is high.
- rst asserted mid-operation: any pending output word is discarded. No ready is given during the rst cycle.
- Latency: a word accepted in cycle t appears with out_valid = 1 in cycle t+1.
- Throughput: one word per cycle while out_ready stays high.
- Backpressure: while out_valid && !out_ready, out_data and out_id are held stable, and req_ready = 0.
- Drain and refill in the same cycle: out_valid stays 1 and out_data updates to the new word.
- Fairness: with both requesters continuously valid and out_ready = 1, grants alternate 0, 1, 0, 1, …
- Requester starvation is bounded by one foreign grant.

## Structure
- Shared package perm_pkg:
  - typedef enum logic [1:0] perm_mode_t: PERM_PASS = 0, PERM_REV = 1, PERM_ROT = 2, PERM_RSVD = 3.
  - Function perm_is_legal(perm_mode_t).
- Sub-module perm_net:
  - Purely combinational; parameter W; ports in, mode, out.
  - Instantiated once. It is the only place the permutation is implemented.
- Top level holds: grant logic, ptr register, output register and err register.

## Test plan
- Reset, then req_valid = 0 → out_valid = 0, out_data = 0, err = 0, req_ready = 2'b00.
- Req0 only, W = 4:
  - data 4'b1010 PASS → out_data 4'b1010, out_id 0, one cycle later.
  - data 4'b0011 REV → 4'b1100.
  - data 4'b0001 ROT → 4'b1000.
  - data 4'b0110 ROT → 4'b0011.
- Both valid from reset with out_ready = 1:
  - Req0 data 4'b0001 ROT, req1 data 4'b0001 REV.
  - Required: outputs 4'b1000 (id 0), 4'b1000 (id 1), 4'b1000 (id 0), … with alternating out_id.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles after the first result → out_data stable, req_ready = 00 throughout.
  - Release → the next word appears the following cycle, with no word lost or duplicated.
- Accept req1 with mode 3 and data 4'b0101 → out_data 4'b0101, err = 1 from the next cycle. err stays 1 until rst.
- Assert rst while out_valid = 1 and both requesters valid → next cycle out_valid = 0, ptr = 0. The first post-reset grant goes to req0.
